// File: rtl/crc32_stream_if.sv
// Frame-data and result handshake bundle for the streaming CRC-32 engine.
interface crc32_stream_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16
);
  logic                    i_crc_clear;
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic [DATA_WIDTH/8-1:0] s_axis_tkeep;
  logic                    s_axis_tvalid;
  logic                    s_axis_tlast;
  logic                    s_axis_tready;
  logic [31:0]             o_crc;
  logic                    o_crc_good;
  logic [LEN_WIDTH-1:0]    o_frame_len;
  logic                    o_crc_valid;
  logic                    i_crc_ready;

  // Engine side
  modport slave (
    input  i_crc_clear, s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, i_crc_ready,
    output s_axis_tready, o_crc, o_crc_good, o_frame_len, o_crc_valid
  );

  // Parent side
  modport master (
    output i_crc_clear, s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, i_crc_ready,
    input  s_axis_tready, o_crc, o_crc_good, o_frame_len, o_crc_valid
  );
endinterface

// File: rtl/crc32_stream.sv
// Streaming reflected CRC-32 engine: folds up to DATA_WIDTH/8 kept bytes per beat
// and presents FCS, residue check and byte count on a valid/ready result port.
module crc32_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [31:0] POLY       = 32'h04C11DB7,
  parameter logic [31:0] INIT       = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE    = 32'h2144DF1C,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input logic           i_clk,
  input logic           i_reset_n,
  crc32_stream_if.slave bus
);

  localparam int unsigned KEEP_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = $clog2(KEEP_W + 1);
  localparam int unsigned SUM_W  = LEN_WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_HOLD} state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int unsigned k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

  localparam logic [31:0] POLY_REF = reflect32(POLY);

  // One byte through the LSB-first shift register; unrolls to an XOR network.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int unsigned k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY_REF) : (c >> 1);
    return c;
  endfunction

  state_t               state_q, state_d;
  logic [31:0]          crc_q, crc_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [31:0]          res_crc_q, res_crc_d;
  logic                 res_good_q, res_good_d;
  logic [LEN_WIDTH-1:0] res_len_q, res_len_d;
  logic                 res_valid_q, res_valid_d;

  logic [31:0]          crc_next_c;
  logic [CNT_W-1:0]     pop_c;
  logic [SUM_W-1:0]     len_sum_c;
  logic [LEN_WIDTH-1:0] len_next_c;
  logic [31:0]          fcs_c;
  logic                 tready_c;
  logic                 accept_c;

  assign tready_c = ((state_q != ST_HOLD) | bus.i_crc_ready) & ~bus.i_crc_clear;
  assign accept_c = bus.s_axis_tvalid & tready_c;
  assign fcs_c    = crc_next_c ^ XOR_OUT;

  // Fold kept lanes into the running CRC, lane 0 first, and count them.
  always_comb begin
    crc_next_c = crc_q;
    pop_c      = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      if (bus.s_axis_tkeep[i]) begin
        crc_next_c = crc_byte(crc_next_c, bus.s_axis_tdata[8*i +: 8]);
        pop_c      = pop_c + CNT_W'(1);
      end
    end
  end

  // Byte count with saturation at all-ones.
  always_comb begin
    len_sum_c  = {1'b0, len_q} + SUM_W'(pop_c);
    len_next_c = len_sum_c[LEN_WIDTH] ? '1 : len_sum_c[LEN_WIDTH-1:0];
  end

  // Next-state: clear wins, then result acceptance, then beat acceptance.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    len_d       = len_q;
    res_crc_d   = res_crc_q;
    res_good_d  = res_good_q;
    res_len_d   = res_len_q;
    res_valid_d = res_valid_q;
    if (bus.i_crc_clear) begin
      state_d     = ST_IDLE;
      crc_d       = INIT;
      len_d       = '0;
      res_valid_d = 1'b0;
    end else begin
      if ((state_q == ST_HOLD) && bus.i_crc_ready) begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
      if (accept_c) begin
        if (bus.s_axis_tlast) begin
          state_d     = ST_HOLD;
          crc_d       = INIT;
          len_d       = '0;
          res_crc_d   = fcs_c;
          res_good_d  = (fcs_c == RESIDUE);
          res_len_d   = len_next_c;
          res_valid_d = 1'b1;
        end else begin
          state_d = ST_FRAME;
          crc_d   = crc_next_c;
          len_d   = len_next_c;
        end
      end
    end
  end

  // State and result registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      crc_q       <= INIT;
      len_q       <= '0;
      res_crc_q   <= '0;
      res_good_q  <= 1'b0;
      res_len_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      res_crc_q   <= res_crc_d;
      res_good_q  <= res_good_d;
      res_len_q   <= res_len_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.s_axis_tready = tready_c;
  assign bus.o_crc         = res_crc_q;
  assign bus.o_crc_good    = res_good_q;
  assign bus.o_frame_len   = res_len_q;
  assign bus.o_crc_valid   = res_valid_q;

endmodule

// File: tb/tb_crc32_stream.sv
// Bench for crc32_stream: 8-bit and 32-bit instances against a whole-frame CRC model.
module tb_crc32_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  crc32_stream_if #(.DATA_WIDTH(8))  i8 ();
  crc32_stream_if #(.DATA_WIDTH(32)) i32 ();

  crc32_stream #(.DATA_WIDTH(8))  dut8  (.i_clk(clk), .i_reset_n(rst_n), .bus(i8));
  crc32_stream #(.DATA_WIDTH(32)) dut32 (.i_clk(clk), .i_reset_n(rst_n), .bus(i32));

  int checks = 0;
  int errors = 0;

  // Model state per instance (0 = 8-bit, 1 = 32-bit)
  logic [7:0]  fbuf [2][0:63];
  int          fcnt [2];
  int unsigned acc_len [2];
  logic        exp_valid [2];
  logic [31:0] exp_crc [2];
  logic        exp_good [2];
  logic [15:0] exp_len [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Plain bitwise CRC-32 over the whole buffered frame.
  function automatic logic [31:0] ref_crc(input int d);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < fcnt[d]; k++) begin
      c = c ^ {24'h0, fbuf[d][k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c ^ 32'hFFFFFFFF;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_valid[d] = 1'b0; exp_crc[d] = '0; exp_good[d] = 1'b0; exp_len[d] = '0;
      fcnt[d] = 0; acc_len[d] = 0;
    end
  endtask

  task automatic model_cycle(input int d, input logic clr, input logic rdy, input logic tv,
                             input logic tl, input logic [63:0] data, input logic [7:0] keep,
                             input int lanes);
    logic acc;
    acc = tv && !(exp_valid[d] && !rdy) && !clr;
    if (clr) begin
      fcnt[d] = 0; acc_len[d] = 0; exp_valid[d] = 1'b0;
    end else begin
      if (exp_valid[d] && rdy) exp_valid[d] = 1'b0;
      if (acc) begin
        for (int i = 0; i < lanes; i++) begin
          if (keep[i]) begin
            if (fcnt[d] < 64) fbuf[d][fcnt[d]] = data[8*i +: 8];
            fcnt[d]++;
            if (acc_len[d] < 65535) acc_len[d]++;
          end
        end
        if (tl) begin
          exp_crc[d]   = ref_crc(d);
          exp_good[d]  = (exp_crc[d] == 32'h2144DF1C);
          exp_len[d]   = 16'(acc_len[d]);
          exp_valid[d] = 1'b1;
          fcnt[d] = 0; acc_len[d] = 0;
        end
      end
    end
  endtask

  // Model advances on the same edge the engine does.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_cycle(0, i8.i_crc_clear, i8.i_crc_ready, i8.s_axis_tvalid, i8.s_axis_tlast,
                  {56'h0, i8.s_axis_tdata}, {7'h0, i8.s_axis_tkeep}, 1);
      model_cycle(1, i32.i_crc_clear, i32.i_crc_ready, i32.s_axis_tvalid, i32.s_axis_tlast,
                  {32'h0, i32.s_axis_tdata}, {4'h0, i32.s_axis_tkeep}, 4);
    end
  end

  task automatic cmp(input string tag, input int d, input logic tready, input logic valid,
                     input logic [31:0] crc, input logic good, input logic [15:0] len,
                     input logic clr, input logic rdy);
    logic exp_tr;
    exp_tr = !(exp_valid[d] && !rdy) && !clr;
    check({tag, " tready"}, {31'h0, tready}, {31'h0, exp_tr});
    check({tag, " valid"},  {31'h0, valid},  {31'h0, exp_valid[d]});
    check({tag, " crc"},    crc,             exp_crc[d]);
    check({tag, " good"},   {31'h0, good},   {31'h0, exp_good[d]});
    check({tag, " len"},    {16'h0, len},    {16'h0, exp_len[d]});
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      cmp("dw8", 0, i8.s_axis_tready, i8.o_crc_valid, i8.o_crc, i8.o_crc_good,
          i8.o_frame_len, i8.i_crc_clear, i8.i_crc_ready);
      cmp("dw32", 1, i32.s_axis_tready, i32.o_crc_valid, i32.o_crc, i32.o_crc_good,
          i32.o_frame_len, i32.i_crc_clear, i32.i_crc_ready);
    end
  end

  task automatic beat8(input logic [7:0] d, input logic last, output int waited);
    logic acc;
    i8.s_axis_tdata = d; i8.s_axis_tkeep = 1'b1; i8.s_axis_tvalid = 1'b1; i8.s_axis_tlast = last;
    waited = 0; acc = 1'b0;
    while (!acc && waited < 50) begin
      @(negedge clk); acc = i8.s_axis_tready;
      @(posedge clk); #1; waited++;
    end
    if (!acc) begin checks++; errors++; $display("FAIL dw8 accept timeout @%0t", $time); end
    i8.s_axis_tvalid = 1'b0; i8.s_axis_tlast = 1'b0;
  endtask

  task automatic beat32(input logic [31:0] d, input logic [3:0] keep, input logic last);
    logic acc;
    int   waited;
    i32.s_axis_tdata = d; i32.s_axis_tkeep = keep; i32.s_axis_tvalid = 1'b1; i32.s_axis_tlast = last;
    waited = 0; acc = 1'b0;
    while (!acc && waited < 50) begin
      @(negedge clk); acc = i32.s_axis_tready;
      @(posedge clk); #1; waited++;
    end
    if (!acc) begin checks++; errors++; $display("FAIL dw32 accept timeout @%0t", $time); end
    i32.s_axis_tvalid = 1'b0; i32.s_axis_tlast = 1'b0;
  endtask

  task automatic lit8(input string name, input logic valid, input logic [31:0] crc,
                      input logic good, input logic [15:0] len);
    check({name, " valid"}, {31'h0, i8.o_crc_valid}, {31'h0, valid});
    check({name, " crc"},   i8.o_crc, crc);
    check({name, " good"},  {31'h0, i8.o_crc_good}, {31'h0, good});
    check({name, " len"},   {16'h0, i8.o_frame_len}, {16'h0, len});
  endtask

  task automatic lit32(input string name, input logic valid, input logic [31:0] crc,
                       input logic good, input logic [15:0] len);
    check({name, " valid"}, {31'h0, i32.o_crc_valid}, {31'h0, valid});
    check({name, " crc"},   i32.o_crc, crc);
    check({name, " good"},  {31'h0, i32.o_crc_good}, {31'h0, good});
    check({name, " len"},   {16'h0, i32.o_frame_len}, {16'h0, len});
  endtask

  task automatic send_123456789_dw8();
    int w;
    for (int i = 0; i < 9; i++) beat8(8'(8'h31 + i), (i == 8), w);
  endtask

  task automatic send_123456789_dw32();
    beat32(32'h34333231, 4'hF, 1'b0);
    beat32(32'h38373635, 4'hF, 1'b0);
    beat32(32'h00000039, 4'h1, 1'b1);
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    i8.i_crc_clear = 1'b0;  i8.s_axis_tdata = '0;  i8.s_axis_tkeep = '0;
    i8.s_axis_tvalid = 1'b0;  i8.s_axis_tlast = 1'b0;  i8.i_crc_ready = 1'b1;
    i32.i_crc_clear = 1'b0; i32.s_axis_tdata = '0; i32.s_axis_tkeep = '0;
    i32.s_axis_tvalid = 1'b0; i32.s_axis_tlast = 1'b0; i32.i_crc_ready = 1'b1;
    #12;
    lit8("reset dw8", 1'b0, 32'h0, 1'b0, 16'd0);
    lit32("reset dw32", 1'b0, 32'h0, 1'b0, 16'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Check string, byte-wide
    send_123456789_dw8();
    lit8("check dw8", 1'b1, 32'hCBF43926, 1'b0, 16'd9);
    @(posedge clk); #1;
    lit8("after accept dw8", 1'b0, 32'hCBF43926, 1'b0, 16'd9);

    // Check string, word-wide with partial last beat
    send_123456789_dw32();
    lit32("check dw32", 1'b1, 32'hCBF43926, 1'b0, 16'd9);
    @(posedge clk); #1;

    // Empty-keep beat mid-frame contributes nothing
    beat32(32'h34333231, 4'hF, 1'b0);
    beat32(32'hDEADBEEF, 4'h0, 1'b0);
    beat32(32'h38373635, 4'hF, 1'b0);
    beat32(32'h00000039, 4'h1, 1'b1);
    lit32("keep0 dw32", 1'b1, 32'hCBF43926, 1'b0, 16'd9);
    @(posedge clk); #1;

    // Frame with its own FCS appended hits the residue
    beat32(32'h34333231, 4'hF, 1'b0);
    beat32(32'h38373635, 4'hF, 1'b0);
    beat32(32'hF4392639, 4'hF, 1'b0);
    beat32(32'h000000CB, 4'h1, 1'b1);
    lit32("residue dw32", 1'b1, 32'h2144DF1C, 1'b1, 16'd13);
    @(posedge clk); #1;

    // Single corrupted bit breaks the residue
    beat32(32'h34333230, 4'hF, 1'b0);
    beat32(32'h38373635, 4'hF, 1'b0);
    beat32(32'hF4392639, 4'hF, 1'b0);
    beat32(32'h000000CB, 4'h1, 1'b1);
    check("bitflip dw32 good", {31'h0, i32.o_crc_good}, 32'h0);
    check("bitflip dw32 len", {16'h0, i32.o_frame_len}, 32'd13);
    @(posedge clk); #1;

    // Result held under backpressure; next beat waits, then goes with the accept
    i8.i_crc_ready = 1'b0;
    beat8(8'h00, 1'b1, w);
    i8.s_axis_tdata = 8'h31; i8.s_axis_tkeep = 1'b1; i8.s_axis_tvalid = 1'b1; i8.s_axis_tlast = 1'b1;
    for (int c = 0; c < 5; c++) begin
      lit8("hold dw8", 1'b1, 32'hD202EF8D, 1'b0, 16'd1);
      check("hold dw8 tready", {31'h0, i8.s_axis_tready}, 32'h0);
      @(posedge clk); #1;
    end
    i8.i_crc_ready = 1'b1;
    @(negedge clk);
    check("release dw8 tready", {31'h0, i8.s_axis_tready}, 32'h1);
    @(posedge clk); #1;
    i8.s_axis_tvalid = 1'b0; i8.s_axis_tlast = 1'b0;
    lit8("release dw8", 1'b1, 32'h83DCEFB7, 1'b0, 16'd1);
    @(posedge clk); #1;

    // Back-to-back one-byte frames at full rate
    for (int n = 0; n < 6; n++) begin
      beat8(8'h00, 1'b1, w);
      check("b2b dw8 wait", 32'(w), 32'd1);
      lit8("b2b dw8", 1'b1, 32'hD202EF8D, 1'b0, 16'd1);
    end
    @(posedge clk); #1;

    // Abort mid-frame with clear; presented beat is refused
    for (int i = 0; i < 4; i++) beat8(8'(8'h31 + i), 1'b0, w);
    i8.i_crc_clear = 1'b1;
    i8.s_axis_tdata = 8'h35; i8.s_axis_tkeep = 1'b1; i8.s_axis_tvalid = 1'b1;
    @(negedge clk);
    check("clear dw8 tready", {31'h0, i8.s_axis_tready}, 32'h0);
    @(posedge clk); #1;
    i8.i_crc_clear = 1'b0; i8.s_axis_tvalid = 1'b0;
    check("clear dw8 valid", {31'h0, i8.o_crc_valid}, 32'h0);
    send_123456789_dw8();
    lit8("after clear dw8", 1'b1, 32'hCBF43926, 1'b0, 16'd9);
    @(posedge clk); #1;

    // Abort mid-frame with reset; outputs drop at once
    for (int i = 0; i < 4; i++) beat8(8'(8'h31 + i), 1'b0, w);
    beat32(32'h34333231, 4'hF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    lit8("midreset dw8", 1'b0, 32'h0, 1'b0, 16'd0);
    lit32("midreset dw32", 1'b0, 32'h0, 1'b0, 16'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send_123456789_dw8();
    lit8("after reset dw8", 1'b1, 32'hCBF43926, 1'b0, 16'd9);
    send_123456789_dw32();
    lit32("after reset dw32", 1'b1, 32'hCBF43926, 1'b0, 16'd9);
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
